// File: rtl/cgra_inj_pkg.sv
// Shared definitions for the CPU-side CGRA packet injector.
// Holds packet/bus widths, the MMIO address map, status register bit
// positions and the packed CGRA packet type.
package cgra_inj_pkg;

   localparam int unsigned PKT_HDR_W  = 27;
   localparam int unsigned MCGR_PAY_W = 158;
   localparam int unsigned PKT_W      = PKT_HDR_W + MCGR_PAY_W;
   localparam int unsigned BUS_W      = 32;
   localparam int unsigned NWORDS     = (PKT_W + BUS_W - 1) / BUS_W;
   // Bits of the packet held in the last staging word.
   localparam int unsigned LAST_W     = PKT_W - (NWORDS - 1) * BUS_W;

   localparam logic [2:0] ADDR_COMMIT = 3'd6;
   localparam logic [2:0] ADDR_STATUS = 3'd7;

   localparam int unsigned ST_FULL_BIT  = 8;
   localparam int unsigned ST_EMPTY_BIT = 9;
   localparam int unsigned ST_OVF_BIT   = 10;
   localparam int unsigned ST_DROP_LSB  = 16;

   typedef struct packed {
      logic [PKT_HDR_W-1:0]  hdr;
      logic [MCGR_PAY_W-1:0] payload;
   } cgra_pkt_t;

endpackage

// File: rtl/cgra_pkt_injector_if.sv
// MMIO bus and CGRA send-port signal bundle for cgra_pkt_injector.
//   bus_wr_en/addr/data : CPU write port
//   bus_rd_en/addr      : CPU read request, bus_rd_data registered reply
//   send_pkt__msg/val   : packet at FIFO head toward the CGRA
//   send_pkt__rdy       : CGRA accepts the packet
// slave  : injector view.  master : CPU + CGRA view.
interface cgra_pkt_injector_if;
   import cgra_inj_pkg::*;

   logic             bus_wr_en;
   logic [2:0]       bus_wr_addr;
   logic [BUS_W-1:0] bus_wr_data;
   logic             bus_rd_en;
   logic [2:0]       bus_rd_addr;
   logic [BUS_W-1:0] bus_rd_data;
   logic [PKT_W-1:0] send_pkt__msg;
   logic             send_pkt__val;
   logic             send_pkt__rdy;

   modport slave (
      input  bus_wr_en, bus_wr_addr, bus_wr_data,
      input  bus_rd_en, bus_rd_addr,
      output bus_rd_data,
      output send_pkt__msg, send_pkt__val,
      input  send_pkt__rdy
   );

   modport master (
      output bus_wr_en, bus_wr_addr, bus_wr_data,
      output bus_rd_en, bus_rd_addr,
      input  bus_rd_data,
      input  send_pkt__msg, send_pkt__val,
      output send_pkt__rdy
   );

endinterface

// File: rtl/cgra_inj_fifo.sv
// DEPTH x W packet FIFO with registered storage and no bypass path.
//   clk, reset       : clock, async active-high reset (clears storage too)
//   push, push_data  : write; caller only pushes when !full or popping
//   pop              : read; caller only pops when !empty
//   head             : entry at the read pointer, straight from storage
//   count/full/empty : occupancy
module cgra_inj_fifo
   import cgra_inj_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = PKT_W
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [W-1:0]               push_data,
   input  logic                       pop,
   output logic [W-1:0]               head,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   // DEPTH is a power of two, so pointers wrap by natural overflow.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign head  = mem[rd_ptr];
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/cgra_pkt_injector.sv
// CPU-side transmitter for the multi-CGRA recv_from_cpu_pkt port.
// The CPU fills six staging words over MMIO, then commits; each commit
// queues the staged packet in a FIFO that drains over val/rdy.
//   clk, reset : clock, async active-high reset
//   bus        : MMIO write/read port and send_pkt val/rdy port (slave)
// Address map: 0..5 staging words, 6 commit / sent_count,
// 7 status / overflow clear.
module cgra_pkt_injector
   import cgra_inj_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   cgra_pkt_injector_if.slave   bus
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam logic [BUS_W-1:0] LAST_MASK = {{(BUS_W-LAST_W){1'b0}}, {LAST_W{1'b1}}};

   logic [BUS_W-1:0] stage_q [NWORDS];
   cgra_pkt_t        stage_pkt;
   logic [CW-1:0]    fifo_count;
   logic             fifo_full;
   logic             fifo_empty;
   logic             pop;
   logic             commit;
   logic             push;
   logic             drop;
   logic             clr;
   logic             overflow;
   logic [15:0]      drop_count;
   logic [31:0]      sent_count;
   logic [BUS_W-1:0] status;
   logic [BUS_W-1:0] rd_word;

   assign stage_pkt = {stage_q[5][LAST_W-1:0], stage_q[4], stage_q[3],
                       stage_q[2], stage_q[1], stage_q[0]};

   assign pop    = bus.send_pkt__val & bus.send_pkt__rdy;
   assign commit = bus.bus_wr_en && (bus.bus_wr_addr == ADDR_COMMIT) && bus.bus_wr_data[0];
   // A full FIFO still accepts a commit when the head leaves on the same edge.
   assign push   = commit && (!fifo_full || pop);
   assign drop   = commit && fifo_full && !pop;
   assign clr    = bus.bus_wr_en && (bus.bus_wr_addr == ADDR_STATUS) && bus.bus_wr_data[ST_OVF_BIT];

   // Staging words; unused upper bits of the last word are stored as 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned k = 0; k < NWORDS; k++) stage_q[k] <= '0;
      end else if (bus.bus_wr_en && (bus.bus_wr_addr < 3'(NWORDS))) begin
         if (bus.bus_wr_addr == 3'(NWORDS - 1))
            stage_q[bus.bus_wr_addr] <= bus.bus_wr_data & LAST_MASK;
         else
            stage_q[bus.bus_wr_addr] <= bus.bus_wr_data;
      end
   end

   cgra_inj_fifo #(
      .DEPTH (DEPTH),
      .W     (PKT_W)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (stage_pkt),
      .pop       (pop),
      .head      (bus.send_pkt__msg),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign bus.send_pkt__val = !fifo_empty;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow   <= 1'b0;
         drop_count <= '0;
         sent_count <= '0;
      end else begin
         if (drop) begin
            overflow <= 1'b1;
            if (drop_count != '1) drop_count <= drop_count + 1'b1;
         end else if (clr) begin
            overflow   <= 1'b0;
            drop_count <= '0;
         end
         if (pop) sent_count <= sent_count + 1'b1;
      end
   end

   always_comb begin
      status               = '0;
      status[7:0]          = 8'(fifo_count);
      status[ST_FULL_BIT]  = fifo_full;
      status[ST_EMPTY_BIT] = fifo_empty;
      status[ST_OVF_BIT]   = overflow;
      status[31:16]        = drop_count;
   end

   always_comb begin
      rd_word = '0;
      if (bus.bus_rd_addr < 3'(NWORDS))
         rd_word = stage_q[bus.bus_rd_addr];
      else if (bus.bus_rd_addr == ADDR_COMMIT)
         rd_word = sent_count;
      else
         rd_word = status;
   end

   // Registered read: captures pre-edge state, so same-edge writes are unseen.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)              bus.bus_rd_data <= '0;
      else if (bus.bus_rd_en) bus.bus_rd_data <= rd_word;
   end

endmodule
